switch_debounce: RTL

Conditions the 16 raw slide-switch inputs before they reach the switch PIO's `in_port`. Each bit passes through a two-flop synchronizer and a per-bit stability counter, so that only clean, settled levels reach the Avalon-readable PIO register. Optional single-cycle edge pulses let game logic react to switch toggles without polling. It sits between the top-level switch pins and the switch PIO.

---
 rtl/switch_debounce_pkg.sv | 14 +
 rtl/debounce_bit.sv | 45 ++++
 rtl/switch_debounce.sv | 52 +++++
 3 files changed

// File: rtl/switch_debounce_pkg.sv
// Shared defaults and counter sizing for the switch debouncer.
package switch_debounce_pkg;

  localparam int SW_WIDTH_DEFAULT  = 16;
  localparam int SW_STABLE_DEFAULT = 50000;

  // Counter holds 0 .. stable_cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int stable_cycles);
    int w;
    w = $clog2(stable_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchronizer, stability counter and clean level.
module debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = SW_STABLE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean_q,
  output logic clean_d
);

  localparam int                CNT_W  = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Next clean value is exposed so the top can register edge pulses in step with clean_q.
  always_comb begin
    clean_d = clean_q;
    if ((s2 != clean_q) && (cnt == CNT_TC))
      clean_d = s2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      cnt     <= '0;
      clean_q <= 1'b0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      clean_q <= clean_d;
      if ((s2 == clean_q) || (cnt == CNT_TC))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// Debounces WIDTH slide switches; define SWITCH_DEBOUNCE_EDGE_EN to build the
// rise/fall/changed pulse outputs, otherwise they are tied to 0.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH         = SW_WIDTH_DEFAULT,
  parameter int STABLE_CYCLES = SW_STABLE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  logic [WIDTH-1:0] clean_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .raw    (sw_raw[i]),
      .clean_q(sw_clean[i]),
      .clean_d(clean_d[i])
    );
  end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_rise    <= '0;
      sw_fall    <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_rise    <= clean_d & ~sw_clean;
      sw_fall    <= ~clean_d & sw_clean;
      sw_changed <= |(clean_d ^ sw_clean);
    end
  end
`else
  logic unused_clean_d;
  assign unused_clean_d = ^clean_d;
  assign sw_rise        = '0;
  assign sw_fall        = '0;
  assign sw_changed     = 1'b0;
`endif

endmodule
